cdb_writeback: RTL and testbench
================================

Name: cdb_writeback

Overview:
- Common-data-bus stage of the Tomasulo core. Arbitrates completed results from the functional units, for example the adder RS, the multiplier RS and the load buffer.
- Broadcasts one result per cycle to the reservation stations.
- Holds the register status table (Qi per architectural register).
- Drives the single write port of the 8x16 register bank.
- Writes a register only when the broadcast tag is still that register's current producer.

Parameters:
N_FU, 3, number of producing functional units
TAG_W, 3, reservation-station tag width; tag 0 reserved as TAG_NONE ("value in register")
DATA_W, 16, result/register data width
N_REG, 8, architectural registers (index width 3)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
issue_valid  input  1  issue stage renames a destination this cycle
issue_reg  input  3  destination register being renamed
issue_tag  input  TAG_W  tag of the issuing RS; never TAG_NONE
fu_valid  input  N_FU  unit i holds a finished result
fu_tag  input  N_FU*TAG_W  result tags; unit i at bits [i*TAG_W +: TAG_W]
fu_data  input  N_FU*DATA_W  result data, same packing
fu_ready  output  N_FU  grant; result i is consumed when fu_valid[i] & fu_ready[i]
cdb_valid  output  1  broadcast valid
cdb_tag  output  TAG_W  broadcast tag
cdb_data  output  DATA_W  broadcast data
wb_en  output  1  register-bank write enable (to habEscr)
wb_reg  output  3  register-bank write index (to regEscr)
wb_data  output  DATA_W  register-bank write data (to dadoEscr)
qi_flat  output  N_REG*TAG_W  current Qi of every register, for operand lookup at issue

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all Qi = TAG_NONE
  - cdb_valid=0, cdb_tag=0, cdb_data=0
  - wb_en=0, wb_reg=0, wb_data=0
  - round-robin pointer = 0
  - fu_ready is combinational and forced to 0 while reset_n=0.
- Arbitration (combinational):
  - fu_ready is one-hot or zero.
  - Scan starts at the pointer and wraps modulo N_FU; the first set fu_valid wins.
  - Any valid request is always granted; there is no downstream backpressure.
- Pointer update: on a grant to unit g, the pointer becomes (g+1) mod N_FU at the edge. Otherwise it is unchanged.
- Broadcast, 1-cycle latency:
  - At the edge where a grant occurs, cdb_valid/cdb_tag/cdb_data register the winner's valid/tag/data.
  - With no grant, cdb_valid=0 next cycle; tag/data hold their last values.
- Writeback match:
  - At the same edge, find register r with Qi[r]==winner tag. At most one exists, because issue always overwrites.
  - If found and not overridden by issue (see next item): wb_en=1, wb_reg=r, wb_data=winner data; Qi[r] becomes TAG_NONE.
  - If no match, the result is stale or the register was renamed: wb_en=0, and wb_reg/wb_data hold.
  - wb_en asserts in the same cycle as the matching cdb_valid. The bank commits on the following edge.
- Issue:
  - On issue_valid, Qi[issue_reg] <= issue_tag at the edge.
  - If the same edge also matches register issue_reg, issue wins: Qi = issue_tag and wb_en=0, because a younger instruction owns the register.
  - Issue to a different register and a writeback match proceed together.
  - issue_tag equal to the tag being broadcast in the same cycle is illegal; the bench asserts on it.
- fu_tag == TAG_NONE with fu_valid=1 is illegal. The design grants it but never matches a register.
- qi_flat reflects registered Qi. There is no bypass of same-cycle issue or clear.
- Reset mid-operation: in-flight broadcast and wb_en drop immediately; all Qi clear, so pending renames are lost and the issue logic must restart.

Decomposition:
- Shared package tomasulo_pkg:
  - TAG_W, DATA_W, N_REG, N_FU
  - TAG_NONE = 0
  - FU index constants FU_ADD=0, FU_MUL=1, FU_LOAD=2
- Sub-module rr_arbiter:
  - parameter N
  - ports: req[N], pointer in, grant one-hot, grant index, any
  - combinational only
- Pointer register, Qi table and output registers live in cdb_writeback.

Test Plan:
- Reset release, then issue reg3 tag5 → qi_flat shows Qi[3]=5. fu_valid=001, tag5, data 16'h1234 → fu_ready=001; next cycle cdb_valid=1/tag5/1234 and wb_en=1/reg3/1234; Qi[3]=0.
- Issue reg2 tag1, then issue reg2 tag4; fu0 finishes tag1 data 16'hAAAA → cdb_valid=1 tag1, wb_en=0, Qi[2] stays 4.
- Pointer=0, fu_valid=111 held for 4 cycles → grants 001,010,100,001; cdb_tag follows the granted units in that order.
- Same cycle: issue reg6 tag2 while fu1 completes tag7, which currently owns reg6 → Qi[6]=2, wb_en=0, cdb_valid=1 tag7.
- Same cycle: issue reg1 tag3 while fu2 completes tag6 owning reg4 → Qi[1]=3, wb_en=1 reg4, Qi[4]=0.
- Assert reset_n=0 mid-burst with cdb_valid=1 → cdb_valid, wb_en and fu_ready drop asynchronously; all Qi=0; after release the first grant goes to fu0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, reserved tag and functional-unit indices.
package tomasulo_pkg;

    localparam int unsigned N_FU   = 3;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_REG  = 8;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned PTR_W  = 2;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [PTR_W-1:0]  fu_idx_t;

    // Tag 0 means "value is in the register file, no pending producer".
    localparam tag_t TAG_NONE = '0;

    localparam int unsigned FU_ADD  = 0;
    localparam int unsigned FU_MUL  = 1;
    localparam int unsigned FU_LOAD = 2;

    function automatic fu_idx_t ptr_next(input fu_idx_t g);
        return (g == fu_idx_t'(N_FU - 1)) ? '0 : g + fu_idx_t'(1);
    endfunction

endpackage

// File: rtl/cdb_writeback_if.sv
// Issue, functional-unit result and broadcast/writeback signals of the CDB stage.
interface cdb_writeback_if;
    import tomasulo_pkg::*;

    logic                    issue_valid;
    logic [REG_W-1:0]        issue_reg;
    logic [TAG_W-1:0]        issue_tag;
    logic [N_FU-1:0]         fu_valid;
    logic [N_FU*TAG_W-1:0]   fu_tag;
    logic [N_FU*DATA_W-1:0]  fu_data;
    logic [N_FU-1:0]         fu_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic                    wb_en;
    logic [REG_W-1:0]        wb_reg;
    logic [DATA_W-1:0]       wb_data;
    logic [N_REG*TAG_W-1:0]  qi_flat;

    modport master (
        output issue_valid, issue_reg, issue_tag, fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_valid, cdb_tag, cdb_data, wb_en, wb_reg, wb_data, qi_flat
    );

    modport slave (
        input  issue_valid, issue_reg, issue_tag, fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_valid, cdb_tag, cdb_data, wb_en, wb_reg, wb_data, qi_flat
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [2*N-1:0] rot;
    int unsigned    win;

    // Bit k of rot is request (ptr+k) mod N, so a forward scan implements the wrap.
    always_comb begin
        rot         = {req_i, req_i} >> ptr_i;
        grant_idx_o = '0;
        any_o       = 1'b0;
        win         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                win   = 32'(ptr_i) + k;
                if (win >= N) win = win - N;
            end
        end
        grant_idx_o = IDX_W'(win);
    end

    always_comb begin
        grant_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (any_o && (win == j)) grant_o[j] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_writeback.sv
// Common-data-bus stage: arbitrates FU results, broadcasts one per cycle,
// keeps the register status (Qi) table and drives the register-bank write port.
module cdb_writeback
    import tomasulo_pkg::*;
(
    input logic           clock,
    input logic           reset_n,
    cdb_writeback_if.slave bus
);

    logic [N_FU-1:0] grant;
    fu_idx_t         grant_idx;
    logic            grant_any;

    fu_idx_t  ptr_q, ptr_d;
    tag_t     qi_q [N_REG];
    tag_t     qi_d [N_REG];
    logic     cdb_valid_q, cdb_valid_d;
    tag_t     cdb_tag_q, cdb_tag_d;
    data_t    cdb_data_q, cdb_data_d;
    logic     wb_en_q, wb_en_d;
    reg_idx_t wb_reg_q, wb_reg_d;
    data_t    wb_data_q, wb_data_d;

    tag_t     win_tag;
    data_t    win_data;
    logic     match;
    reg_idx_t match_reg;
    logic     wb_fire;

    rr_arbiter #(
        .N     (N_FU),
        .IDX_W (PTR_W)
    ) u_arb (
        .req_i       (bus.fu_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    assign bus.fu_ready = reset_n ? grant : '0;

    always_comb begin
        win_tag  = TAG_NONE;
        win_data = '0;
        for (int unsigned i = 0; i < N_FU; i++) begin
            if (grant[i]) begin
                win_tag  = bus.fu_tag[i*TAG_W +: TAG_W];
                win_data = bus.fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // TAG_NONE never matches, otherwise every idle register would look like a producer.
    always_comb begin
        match     = 1'b0;
        match_reg = '0;
        for (int unsigned r = 0; r < N_REG; r++) begin
            if (grant_any && (win_tag != TAG_NONE) && (qi_q[r] == win_tag)) begin
                match     = 1'b1;
                match_reg = reg_idx_t'(r);
            end
        end
    end

    // A same-edge rename of the matched register means a younger producer owns it.
    assign wb_fire = match && !(bus.issue_valid && (bus.issue_reg == match_reg));

    always_comb begin
        for (int unsigned r = 0; r < N_REG; r++) qi_d[r] = qi_q[r];
        if (wb_fire)         qi_d[match_reg]     = TAG_NONE;
        if (bus.issue_valid) qi_d[bus.issue_reg] = bus.issue_tag;

        ptr_d       = grant_any ? ptr_next(grant_idx) : ptr_q;
        cdb_valid_d = grant_any;
        cdb_tag_d   = grant_any ? win_tag  : cdb_tag_q;
        cdb_data_d  = grant_any ? win_data : cdb_data_q;
        wb_en_d     = wb_fire;
        wb_reg_d    = wb_fire ? match_reg : wb_reg_q;
        wb_data_d   = wb_fire ? win_data  : wb_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < N_REG; r++) qi_q[r] <= TAG_NONE;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            wb_en_q     <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
        end else begin
            for (int unsigned r = 0; r < N_REG; r++) qi_q[r] <= qi_d[r];
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            wb_en_q     <= wb_en_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
        end
    end

    always_comb begin
        bus.qi_flat = '0;
        for (int unsigned r = 0; r < N_REG; r++) bus.qi_flat[r*TAG_W +: TAG_W] = qi_q[r];
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.wb_en     = wb_en_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios plus random traffic checked against a
// register-status reference model.
module tb_cdb_writeback;
    import tomasulo_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    cdb_writeback_if bus();

    cdb_writeback dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference state: owner tag per register, RR pointer, and last broadcast/write.
    int   m_qi [N_REG];
    int   m_ptr;
    logic m_cv;
    int   m_ct, m_cd;
    logic m_we;
    int   m_wr, m_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model_reset();
        for (int r = 0; r < N_REG; r++) m_qi[r] = 0;
        m_ptr = 0; m_cv = 1'b0; m_ct = 0; m_cd = 0;
        m_we = 1'b0; m_wr = 0; m_wd = 0;
    endfunction

    function automatic int pick(input logic [2:0] fv);
        for (int k = 0; k < 3; k++) begin
            if (fv[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string ctx);
        logic [N_REG*TAG_W-1:0] q;
        q = '0;
        for (int r = 0; r < N_REG; r++) q[r*TAG_W +: TAG_W] = 3'(m_qi[r]);
        check({ctx, ".cdb_valid"}, 32'(bus.cdb_valid), 32'(m_cv));
        check({ctx, ".cdb_tag"},   32'(bus.cdb_tag),   32'(m_ct));
        check({ctx, ".cdb_data"},  32'(bus.cdb_data),  32'(m_cd));
        check({ctx, ".wb_en"},     32'(bus.wb_en),     32'(m_we));
        check({ctx, ".wb_reg"},    32'(bus.wb_reg),    32'(m_wr));
        check({ctx, ".wb_data"},   32'(bus.wb_data),   32'(m_wd));
        check({ctx, ".qi_flat"},   32'(bus.qi_flat),   32'(q));
    endtask

    // Called right after a negedge: drive, check grant, advance model, check at posedge+1.
    task automatic cycle(input string ctx, input logic iv, input int ir, input int it,
                         input logic [2:0] fv, input logic [8:0] ftp, input logic [47:0] fdp);
        int g, wt, wd, mr;
        bus.issue_valid = iv;
        bus.issue_reg   = 3'(ir);
        bus.issue_tag   = 3'(it);
        bus.fu_valid    = fv;
        bus.fu_tag      = ftp;
        bus.fu_data     = fdp;
        g = pick(fv);
        #1;
        check({ctx, ".fu_ready"}, 32'(bus.fu_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
            wt = 32'(ftp[g*3 +: 3]);
            wd = 32'(fdp[g*16 +: 16]);
            assert (!(iv && (it == wt))) else $error("illegal stimulus: issue tag %0d is being broadcast", it);
            m_cv = 1'b1; m_ct = wt; m_cd = wd;
            m_ptr = (g + 1) % 3;
            mr = -1;
            if (wt != 0) begin
                for (int r = 0; r < N_REG; r++) if (m_qi[r] == wt) mr = r;
            end
            if (mr >= 0 && !(iv && ir == mr)) begin
                m_we = 1'b1; m_wr = mr; m_wd = wd; m_qi[mr] = 0;
            end else begin
                m_we = 1'b0;
            end
        end else begin
            m_cv = 1'b0;
            m_we = 1'b0;
        end
        if (iv) m_qi[ir] = it;
        @(posedge clock);
        #1;
        check_outputs(ctx);
        @(negedge clock);
    endtask

    task automatic do_reset(input string ctx);
        bus.issue_valid = 1'b0;
        bus.fu_valid    = 3'b111;
        reset_n = 1'b0;
        model_reset();
        #1;
        check({ctx, ".fu_ready"}, 32'(bus.fu_ready), 32'd0);
        check_outputs(ctx);
        @(negedge clock);
        reset_n = 1'b1;
        bus.fu_valid = '0;
    endtask

    task automatic rand_cycle();
        int live[$];
        int free[$];
        logic [2:0]  fv;
        logic [8:0]  ftp;
        logic [47:0] fdp;
        int g, wt, t, ir, it;
        logic iv;
        for (int r = 0; r < N_REG; r++) if (m_qi[r] != 0) live.push_back(m_qi[r]);
        fv  = 3'($urandom_range(0, 7));
        ftp = '0;
        fdp = '0;
        for (int u = 0; u < 3; u++) begin
            if (live.size() > 0 && $urandom_range(0, 3) != 0)
                t = live[$urandom_range(0, live.size() - 1)];
            else
                t = $urandom_range(1, 7);
            ftp[u*3 +: 3]   = 3'(t);
            fdp[u*16 +: 16] = 16'($urandom);
        end
        g  = pick(fv);
        wt = (g >= 0) ? 32'(ftp[g*3 +: 3]) : 0;
        for (int tg = 1; tg < 8; tg++) begin
            bit used;
            used = (tg == wt);
            foreach (live[i]) if (live[i] == tg) used = 1'b1;
            if (!used) free.push_back(tg);
        end
        iv = 1'($urandom_range(0, 1));
        ir = $urandom_range(0, 7);
        it = 1;
        if (free.size() == 0) iv = 1'b0;
        else it = free[$urandom_range(0, free.size() - 1)];
        cycle("rnd", iv, ir, it, fv, ftp, fdp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_reg   = '0;
        bus.issue_tag   = '0;
        bus.fu_valid    = '0;
        bus.fu_tag      = '0;
        bus.fu_data     = '0;
        model_reset();
        @(negedge clock);
        do_reset("por");

        // Rename then matching completion writes the register back.
        cycle("iss3", 1'b1, 3, 5, 3'b000, 9'd0, 48'd0);
        check("plan1.qi3", 32'(bus.qi_flat[3*TAG_W +: TAG_W]), 32'd5);
        cycle("wb3", 1'b0, 0, 0, 3'b001, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'h1234});
        check("plan1.wb_reg",  32'(bus.wb_reg),  32'd3);
        check("plan1.wb_data", 32'(bus.wb_data), 32'h1234);

        // Stale tag after a re-rename: broadcast but no write.
        cycle("iss2a", 1'b1, 2, 1, 3'b000, 9'd0, 48'd0);
        cycle("iss2b", 1'b1, 2, 4, 3'b000, 9'd0, 48'd0);
        cycle("stale", 1'b0, 0, 0, 3'b001, {3'd0, 3'd0, 3'd1}, {16'h0, 16'h0, 16'hAAAA});
        check("plan2.wb_en", 32'(bus.wb_en), 32'd0);
        check("plan2.qi2",   32'(bus.qi_flat[2*TAG_W +: TAG_W]), 32'd4);

        // Round-robin rotation from pointer 0.
        do_reset("rr");
        begin
            int exp_tag [4] = '{1, 2, 3, 1};
            for (int c = 0; c < 4; c++) begin
                cycle("rr", 1'b0, 0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {16'h3333, 16'h2222, 16'h1111});
                check("plan3.cdb_tag", 32'(bus.cdb_tag), 32'(exp_tag[c]));
            end
        end

        // Issue to the register being written back wins.
        cycle("iss6", 1'b1, 6, 7, 3'b000, 9'd0, 48'd0);
        cycle("ovr6", 1'b1, 6, 2, 3'b010, {3'd0, 3'd7, 3'd0}, {16'h0, 16'h7777, 16'h0});
        check("plan4.qi6",   32'(bus.qi_flat[6*TAG_W +: TAG_W]), 32'd2);
        check("plan4.wb_en", 32'(bus.wb_en), 32'd0);

        // Issue to another register proceeds alongside the writeback.
        cycle("iss4", 1'b1, 4, 6, 3'b000, 9'd0, 48'd0);
        cycle("par", 1'b1, 1, 3, 3'b100, {3'd6, 3'd0, 3'd0}, {16'h6666, 16'h0, 16'h0});
        check("plan5.wb_reg", 32'(bus.wb_reg), 32'd4);
        check("plan5.qi1",    32'(bus.qi_flat[1*TAG_W +: TAG_W]), 32'd3);
        check("plan5.qi4",    32'(bus.qi_flat[4*TAG_W +: TAG_W]), 32'd0);

        // Asynchronous reset in the middle of a burst.
        cycle("iss5", 1'b1, 5, 1, 3'b000, 9'd0, 48'd0);
        cycle("burst", 1'b0, 0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {16'hCCCC, 16'hBBBB, 16'hBEEF});
        check("plan6.wb_en_before", 32'(bus.wb_en), 32'd1);
        do_reset("midrst");
        cycle("after", 1'b0, 0, 0, 3'b111, {3'd3, 3'd2, 3'd1}, {16'hCCCC, 16'hBBBB, 16'hBEEF});
        check("plan6.first_tag", 32'(bus.cdb_tag), 32'd1);

        do_reset("rndrst");
        for (int n = 0; n < 400; n++) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
